// File: rtl/spi_master_engine.sv
// -----------------------------------------------------------------------------
// spi_master_engine
//
// Full-duplex SPI mode-0 (CPOL=0, CPHA=0) shift engine, MSB first. Sits
// between the SPI register file and the pins: a start strobe launches one
// transfer of tx_data, and the received word is returned on rx_data together
// with a single-cycle done pulse.
//
// Parameters
//   DATA_W  : bits per transfer (1..32)
//   CLK_DIV : clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset, overrides everything
//   start   in   begin a transfer (only looked at while idle)
//   tx_data in   word to send, captured when start is accepted
//   busy    out  high from the first SETUP cycle through the DONE cycle
//   done    out  one-cycle pulse, rx_data valid in the same cycle
//   rx_data out  last received word, holds until the next done
//   sclk    out  SPI clock, idles low
//   mosi    out  serial data out
//   miso    in   serial data in, sampled as sclk is driven high
//   cs_n    out  chip select, active low
// -----------------------------------------------------------------------------
module spi_master_engine #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_next;
    logic              div_term;

    assign div_term = (div_cnt == DIV_LAST);
    assign tx_next  = tx_sh << 1;

    // Shift one sampled bit into the LSB; written without a part-select so it
    // stays legal for DATA_W = 1.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh,
                                                   input logic              bit_in);
        return (sh << 1) | DATA_W'(bit_in);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        tx_sh   <= tx_data;
                        rx_sh   <= '0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        mosi    <= tx_data[DATA_W-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_term) begin
                        // First rising edge: the slave sees the MSB for a
                        // full half-period before it, and miso is sampled now.
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        rx_sh   <= shift_in(rx_sh, miso);
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT: begin
                    // SHIFT spans 2*DATA_W half-periods: DATA_W high/low pairs,
                    // the last low half finishing before HOLD begins.
                    if (div_term) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_ALL) begin
                            state <= HOLD;
                        end else if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sh <= shift_in(rx_sh, miso);
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt < BIT_LAST) begin
                                tx_sh <= tx_next;
                                mosi  <= tx_next[DATA_W-1];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                HOLD: begin
                    if (div_term) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sh;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
